// File: rtl/chunk_pkg.sv
// Shared types and width helpers for the chunk render controller.
// States, palette defaults and the counter-width functions used by every port list.
package chunk_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        WAIT  = 3'd2,
        DRAW  = 3'd3,
        NEXT  = 3'd4,
        DONE  = 3'd5
    } crc_state_t;

    localparam logic [23:0] PAL_DEF_ZERO = 24'h000000;
    localparam logic [23:0] PAL_DEF_REST = 24'hFFFFFF;

    // A one-entry range still needs a one-bit counter.
    function automatic int cnt_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic int xc_w(input int x_chunks);
        return cnt_w(x_chunks);
    endfunction

    function automatic int yc_w(input int y_chunks);
        return cnt_w(y_chunks);
    endfunction

    function automatic int x_w(input int x_chunks, input int chunk_size);
        return cnt_w(x_chunks * chunk_size);
    endfunction

    function automatic int y_w(input int y_chunks, input int chunk_size);
        return cnt_w(y_chunks * chunk_size);
    endfunction

endpackage

// File: rtl/chunk_pixel_walker.sv
// Intra-chunk pixel counters: row-major walk over a CHUNK_SIZE x CHUNK_SIZE block.
// Cleared on chunk entry, stepped once per accepted pixel.
module chunk_pixel_walker
    import chunk_pkg::*;
#(
    parameter int   CHUNK_SIZE = 16,
    localparam int  PW         = cnt_w(CHUNK_SIZE)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          i_clear,
    input  logic          i_advance,
    output logic [PW-1:0] o_px,
    output logic [PW-1:0] o_py,
    output logic          o_last
);

    localparam logic [PW-1:0] P_LAST = PW'(CHUNK_SIZE - 1);

    logic [PW-1:0] r_px;
    logic [PW-1:0] r_py;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_px <= '0;
            r_py <= '0;
        end else if (i_clear) begin
            r_px <= '0;
            r_py <= '0;
        end else if (i_advance) begin
            if (r_px == P_LAST) begin
                r_px <= '0;
                r_py <= (r_py == P_LAST) ? '0 : r_py + 1'b1;
            end else begin
                r_px <= r_px + 1'b1;
            end
        end
    end

    assign o_px   = r_px;
    assign o_py   = r_py;
    assign o_last = (r_px == P_LAST) && (r_py == P_LAST);

endmodule

// File: rtl/chunk_render_ctrl.sv
// Raster walk over a chunk grid: fetch each chunk state, map through the palette,
// and stream the chunk's pixels on a valid/ready port; full-frame or dirty-only passes.
module chunk_render_ctrl
    import chunk_pkg::*;
#(
    parameter int  CHUNK_SIZE = 16,
    parameter int  X_CHUNKS   = 40,
    parameter int  Y_CHUNKS   = 30,
    parameter int  DATA_W     = 2,
    localparam int XC_W       = xc_w(X_CHUNKS),
    localparam int YC_W       = yc_w(Y_CHUNKS),
    localparam int X_W        = x_w(X_CHUNKS, CHUNK_SIZE),
    localparam int Y_W        = y_w(Y_CHUNKS, CHUNK_SIZE)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              dirty_only,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic [XC_W-1:0]   rd_x_chunk,
    output logic [YC_W-1:0]   rd_y_chunk,
    output logic              rd_en,
    input  logic [DATA_W-1:0] rd_data,
    input  logic              rd_dirty,
    output logic              clr_dirty,
    input  logic              pal_we,
    input  logic [DATA_W-1:0] pal_idx,
    input  logic [23:0]       pal_rgb,
    output logic              px_valid,
    input  logic              px_ready,
    output logic [X_W-1:0]    x,
    output logic [Y_W-1:0]    y,
    output logic [7:0]        r,
    output logic [7:0]        g,
    output logic [7:0]        b,
    output crc_state_t        dbg_state
);

    localparam int              PW      = cnt_w(CHUNK_SIZE);
    localparam int              PAL_N   = 2 ** DATA_W;
    localparam logic [XC_W-1:0] XC_LAST = XC_W'(X_CHUNKS - 1);
    localparam logic [YC_W-1:0] YC_LAST = YC_W'(Y_CHUNKS - 1);

    crc_state_t      r_state;
    crc_state_t      w_state_nxt;
    logic [XC_W-1:0] r_xc;
    logic [YC_W-1:0] r_yc;
    logic            r_dirty_only;
    logic            r_drawn;
    logic            r_abort_pend;
    logic [23:0]     r_rgb;
    logic [23:0]     r_pal [PAL_N];

    logic [PW-1:0]   w_px;
    logic [PW-1:0]   w_py;
    logic            w_last;
    logic            w_xfer;
    logic            w_draw_sel;
    logic            w_pass_last;

    // Pixel port: a pixel moves on every cycle where px_valid and px_ready are both high;
    // px_valid never drops and x/y/rgb never change until that happens.
    assign px_valid    = (r_state == DRAW);
    assign w_xfer      = px_valid && px_ready;
    assign w_draw_sel  = !r_dirty_only || rd_dirty;
    assign w_pass_last = (r_xc == XC_LAST) && (r_yc == YC_LAST);

    chunk_pixel_walker #(.CHUNK_SIZE(CHUNK_SIZE)) u_walker (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_clear   (r_state == WAIT),
        .i_advance (w_xfer),
        .o_px      (w_px),
        .o_py      (w_py),
        .o_last    (w_last)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (start) w_state_nxt = FETCH;
            FETCH:   w_state_nxt = abort ? DONE : WAIT;
            WAIT: begin
                if (abort)           w_state_nxt = DONE;
                else if (w_draw_sel) w_state_nxt = DRAW;
                else                 w_state_nxt = NEXT;
            end
            // A stalled abort waits for the pixel on the port to be taken.
            DRAW: begin
                if (w_xfer) begin
                    if (abort || r_abort_pend) w_state_nxt = DONE;
                    else if (w_last)           w_state_nxt = NEXT;
                end
            end
            NEXT:    w_state_nxt = (abort || w_pass_last) ? DONE : FETCH;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= IDLE;
            r_xc         <= '0;
            r_yc         <= '0;
            r_dirty_only <= 1'b0;
            r_drawn      <= 1'b0;
            r_abort_pend <= 1'b0;
            r_rgb        <= '0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_xc         <= '0;
                        r_yc         <= '0;
                        r_dirty_only <= dirty_only;
                    end
                end
                WAIT: begin
                    r_drawn      <= w_draw_sel;
                    r_rgb        <= r_pal[rd_data];
                    r_abort_pend <= 1'b0;
                end
                DRAW: begin
                    if (abort && !w_xfer) r_abort_pend <= 1'b1;
                end
                NEXT: begin
                    if (r_xc == XC_LAST) begin
                        r_xc <= '0;
                        r_yc <= (r_yc == YC_LAST) ? '0 : r_yc + 1'b1;
                    end else begin
                        r_xc <= r_xc + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < PAL_N; i++) begin
                r_pal[i] <= (i == 0) ? PAL_DEF_ZERO : PAL_DEF_REST;
            end
        end else if (pal_we) begin
            r_pal[pal_idx] <= pal_rgb;
        end
    end

    assign busy       = (r_state == FETCH) || (r_state == WAIT) ||
                        (r_state == DRAW)  || (r_state == NEXT);
    assign done       = (r_state == DONE);
    assign rd_en      = (r_state == FETCH);
    assign clr_dirty  = (r_state == NEXT) && r_dirty_only && r_drawn;
    assign rd_x_chunk = r_xc;
    assign rd_y_chunk = r_yc;
    assign x          = {r_xc, w_px};
    assign y          = {r_yc, w_py};
    assign r          = r_rgb[23:16];
    assign g          = r_rgb[15:8];
    assign b          = r_rgb[7:0];
    assign dbg_state  = r_state;

endmodule
